// File: rtl/crossing_decision_filter_if.sv
// Verdict stream in, filtered crossing decision out.
// Master drives frame verdicts; slave is the filter.
interface crossing_decision_filter_if #(
  parameter int CW     = 17,
  parameter int WINDOW = 8,
  parameter int HW     = 4
);
  logic          det_valid;
  logic          det_crossing;
  logic [CW-1:0] det_white_count;
  logic          clear;
  logic          crossing_confirmed;
  logic          confirm_pulse;
  logic          release_pulse;
  logic [HW-1:0] hit_count;
  logic [WINDOW-1:0] history;
  logic [15:0]   frame_count;
  logic          stale;

  modport master (
    output det_valid, det_crossing, det_white_count, clear,
    input  crossing_confirmed, confirm_pulse, release_pulse,
    input  hit_count, history, frame_count, stale
  );

  modport slave (
    input  det_valid, det_crossing, det_white_count, clear,
    output crossing_confirmed, confirm_pulse, release_pulse,
    output hit_count, history, frame_count, stale
  );
endinterface

// File: rtl/crossing_decision_filter.sv
// K-of-N temporal vote with hysteresis over per-frame crossing verdicts.
// Flushes history on clear or when the camera stops delivering frames.
module crossing_decision_filter #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int WINDOW         = 8,
  parameter int CONFIRM_K      = 6,
  parameter int RELEASE_K      = 2,
  parameter int MIN_WHITE      = 3840,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic clk,
  input logic rst,
  crossing_decision_filter_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int HW = $clog2(WINDOW + 1);
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [CW-1:0] MIN_W  = CW'(MIN_WHITE);
  localparam logic [HW-1:0] CONF_K = HW'(CONFIRM_K);
  localparam logic [HW-1:0] REL_K  = HW'(RELEASE_K);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_FIRE = TW'(TO_M1);

  if (!(WINDOW >= 2 && RELEASE_K < CONFIRM_K && CONFIRM_K <= WINDOW))
  begin : g_bad_params
    $error("crossing_decision_filter: illegal WINDOW/CONFIRM_K/RELEASE_K");
  end

  typedef enum logic {S_IDLE = 1'b0, S_CONF = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WINDOW-1:0] history_q, history_d;
  logic [HW-1:0]     hit_count_q, hit_count_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              stale_q, stale_d;
  logic              upd_q, upd_d;
  logic              confirm_q, confirm_d;
  logic              release_q, release_d;

  logic hit;
  logic accept;
  logic to_fire;
  logic flush;

  always_comb begin
    hit     = bus.det_crossing && (bus.det_white_count >= MIN_W);
    accept  = bus.det_valid && !bus.clear;
    to_fire = TO_EN && !bus.det_valid && !bus.clear && (idle_q == TO_FIRE);
    flush   = bus.clear || to_fire;

    state_d       = state_q;
    history_d     = history_q;
    hit_count_d   = hit_count_q;
    frame_count_d = frame_count_q;
    idle_d        = idle_q;
    stale_d       = stale_q;
    upd_d         = 1'b0;
    confirm_d     = 1'b0;
    release_d     = 1'b0;

    // A live camera keeps the stall counter at zero, even on a dropped frame.
    if (bus.det_valid) begin
      idle_d = '0;
    end else if (TO_EN && idle_q != TO_MAX) begin
      idle_d = idle_q + 1'b1;
    end

    if (flush) begin
      history_d   = '0;
      hit_count_d = '0;
      state_d     = S_IDLE;
      release_d   = (state_q == S_CONF);
      if (to_fire) begin
        stale_d = 1'b1;
      end
    end else begin
      if (accept) begin
        history_d     = {history_q[WINDOW-2:0], hit};
        hit_count_d   = hit_count_q + HW'(hit) - HW'(history_q[WINDOW-1]);
        frame_count_d = frame_count_q + 16'd1;
        stale_d       = 1'b0;
        upd_d         = 1'b1;
      end
      if (upd_q) begin
        unique case (state_q)
          S_IDLE: begin
            if (hit_count_q >= CONF_K) begin
              state_d   = S_CONF;
              confirm_d = 1'b1;
            end
          end
          S_CONF: begin
            if (hit_count_q <= REL_K) begin
              state_d   = S_IDLE;
              release_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      history_q     <= '0;
      hit_count_q   <= '0;
      frame_count_q <= '0;
      idle_q        <= '0;
      stale_q       <= 1'b0;
      upd_q         <= 1'b0;
      confirm_q     <= 1'b0;
      release_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      history_q     <= history_d;
      hit_count_q   <= hit_count_d;
      frame_count_q <= frame_count_d;
      idle_q        <= idle_d;
      stale_q       <= stale_d;
      upd_q         <= upd_d;
      confirm_q     <= confirm_d;
      release_q     <= release_d;
    end
  end

  assign bus.crossing_confirmed = (state_q == S_CONF);
  assign bus.confirm_pulse      = confirm_q;
  assign bus.release_pulse      = release_q;
  assign bus.hit_count          = hit_count_q;
  assign bus.history            = history_q;
  assign bus.frame_count        = frame_count_q;
  assign bus.stale              = stale_q;
endmodule

// File: tb/tb_crossing_decision_filter.sv
// Directed-vector bench for crossing_decision_filter.
// Small window, short timeout.
module tb_crossing_decision_filter;
  localparam int CW = 17;
  localparam int WIN = 8;
  localparam int HW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_fc = 0;

  crossing_decision_filter_if #(.CW(CW), .WINDOW(WIN), .HW(HW)) bus ();

  crossing_decision_filter #(
    .IMG_WIDTH(320),
    .IMG_HEIGHT(240),
    .WINDOW(WIN),
    .CONFIRM_K(6),
    .RELEASE_K(2),
    .MIN_WHITE(3840),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic c, input int w);
    bus.det_valid       = 1'b1;
    bus.det_crossing    = c;
    bus.det_white_count = CW'(w);
    tick();
    bus.det_valid       = 1'b0;
    bus.det_crossing    = 1'b0;
    exp_fc++;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic conf,
                           input logic [3:0] hc, input logic [7:0] hist);
    chk({tag, ".conf"}, 32'(bus.crossing_confirmed), 32'(conf));
    chk({tag, ".hc"}, 32'(bus.hit_count), 32'(hc));
    chk({tag, ".hist"}, 32'(bus.history), 32'(hist));
  endtask

  initial begin
    bus.det_valid       = 1'b0;
    bus.det_crossing    = 1'b0;
    bus.det_white_count = '0;
    bus.clear           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // reset values
    chk_state("rst", 1'b0, 4'd0, 8'h00);
    chk("rst.fc", 32'(bus.frame_count), 32'd0);
    chk("rst.stale", 32'(bus.stale), 32'd0);
    chk("rst.cp", 32'(bus.confirm_pulse), 32'd0);
    chk("rst.rp", 32'(bus.release_pulse), 32'd0);

    // 1: async reset while confirmed
    for (int i = 0; i < 6; i++) send(1'b1, 5000);
    tick();
    chk("t1.pre", 32'(bus.confirm_pulse), 32'd1);
    tick();
    chk("t1.conf", 32'(bus.crossing_confirmed), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    exp_fc = 0;
    chk_state("t1.async", 1'b0, 4'd0, 8'h00);
    chk("t1.async.fc", 32'(bus.frame_count), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send(1'b1, 5000);
    tick();
    tick();
    chk_state("t1.five", 1'b0, 4'd5, 8'h1f);
    chk("t1.fc", 32'(bus.frame_count), 32'(exp_fc));
    pulse_clear();
    chk("t1.clr.rp", 32'(bus.release_pulse), 32'd0);
    chk_state("t1.clr", 1'b0, 4'd0, 8'h00);

    // 2: six spaced hits
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 5000);
      if (i < 5) repeat (9) tick();
    end
    chk_state("t2.n1", 1'b0, 4'd6, 8'h3f);
    tick();
    chk("t2.n2.conf", 32'(bus.crossing_confirmed), 32'd1);
    chk("t2.n2.cp", 32'(bus.confirm_pulse), 32'd1);
    tick();
    chk("t2.n3.cp", 32'(bus.confirm_pulse), 32'd0);
    chk("t2.n3.conf", 32'(bus.crossing_confirmed), 32'd1);
    pulse_clear();
    chk("t2.clr.rp", 32'(bus.release_pulse), 32'd1);
    chk("t2.clr.fc", 32'(bus.frame_count), 32'(exp_fc));

    // 3: white-count gate boundary
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_fc = 0;
    tick();
    for (int i = 0; i < 8; i++) send(1'b1, 3839);
    chk_state("t3.low", 1'b0, 4'd0, 8'h00);
    chk("t3.fc", 32'(bus.frame_count), 32'd8);
    tick();
    tick();
    chk("t3.conf", 32'(bus.crossing_confirmed), 32'd0);
    send(1'b1, 3840);
    chk_state("t3.edge", 1'b0, 4'd1, 8'h01);
    send(1'b0, 9999);
    chk_state("t3.nocr", 1'b0, 4'd1, 8'h02);

    // 4: release after misses
    pulse_clear();
    for (int i = 0; i < 8; i++) send(1'b1, 5000);
    chk_state("t4.full", 1'b1, 4'd8, 8'hff);
    tick();
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 5000);
      chk($sformatf("t4.miss%0d", i), 32'(bus.hit_count), 32'(7 - i));
    end
    chk("t4.n1.conf", 32'(bus.crossing_confirmed), 32'd1);
    chk("t4.n1.rp", 32'(bus.release_pulse), 32'd0);
    tick();
    chk("t4.n2.rp", 32'(bus.release_pulse), 32'd1);
    chk("t4.n2.conf", 32'(bus.crossing_confirmed), 32'd0);
    tick();
    chk("t4.n3.rp", 32'(bus.release_pulse), 32'd0);

    // 5: stall timeout
    for (int i = 0; i < 6; i++) send(1'b1, 5000);
    chk_state("t5.hits", 1'b0, 4'd6, 8'h3f);
    tick();
    tick();
    chk("t5.conf", 32'(bus.crossing_confirmed), 32'd1);
    repeat (97) tick();
    chk("t5.pre.stale", 32'(bus.stale), 32'd0);
    chk("t5.pre.conf", 32'(bus.crossing_confirmed), 32'd1);
    tick();
    chk("t5.stale", 32'(bus.stale), 32'd1);
    chk("t5.rp", 32'(bus.release_pulse), 32'd1);
    chk_state("t5.flush", 1'b0, 4'd0, 8'h00);
    tick();
    chk("t5.rp.off", 32'(bus.release_pulse), 32'd0);
    repeat (20) tick();
    chk("t5.hold.stale", 32'(bus.stale), 32'd1);
    chk("t5.hold.rp", 32'(bus.release_pulse), 32'd0);
    send(1'b0, 0);
    chk("t5.unstale", 32'(bus.stale), 32'd0);
    chk("t5.fc", 32'(bus.frame_count), 32'(exp_fc));

    // 6: clear beats det_valid, then back-to-back hits
    for (int i = 0; i < 6; i++) send(1'b1, 5000);
    tick();
    tick();
    chk("t6.conf", 32'(bus.crossing_confirmed), 32'd1);
    bus.clear           = 1'b1;
    bus.det_valid       = 1'b1;
    bus.det_crossing    = 1'b1;
    bus.det_white_count = CW'(5000);
    tick();
    bus.clear     = 1'b0;
    bus.det_valid = 1'b0;
    chk_state("t6.clr", 1'b0, 4'd0, 8'h00);
    chk("t6.clr.rp", 32'(bus.release_pulse), 32'd1);
    chk("t6.clr.fc", 32'(bus.frame_count), 32'(exp_fc));
    for (int i = 0; i < 6; i++) send(1'b1, 5000);
    chk_state("t6.six", 1'b0, 4'd6, 8'h3f);
    chk("t6.six.rp", 32'(bus.release_pulse), 32'd0);
    send(1'b1, 5000);
    chk("t6.n2.conf", 32'(bus.crossing_confirmed), 32'd1);
    chk("t6.n2.cp", 32'(bus.confirm_pulse), 32'd1);
    send(1'b1, 5000);
    chk("t6.n3.cp", 32'(bus.confirm_pulse), 32'd0);
    chk_state("t6.eight", 1'b1, 4'd8, 8'hff);
    chk("t6.fc", 32'(bus.frame_count), 32'(exp_fc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
